// File: rtl/eng_outbuf_pkg.sv
// Shared engine defaults, entry-width helper and the flattened-entry index function
// used by the engine->outbuf write path.
package eng_pkg;

  localparam int ENG_UNITS_DEF = 128;
  localparam int ENG_W_DEF     = 4;
  localparam int ENG_PL_DEF    = 2;

  function automatic int entry_width(input int units, input int w_num, input int pl);
    return units * w_num * pl;
  endfunction

  localparam int ENG_ENTRY_W = entry_width(ENG_UNITS_DEF, ENG_W_DEF, ENG_PL_DEF);

  typedef logic [ENG_ENTRY_W-1:0] entry_t;

  // Bit position of packet bit b of plane w of unit u inside a flattened entry.
  function automatic int unit_plane_bit_idx(input int u, input int w, input int b,
                                            input int w_num = ENG_W_DEF,
                                            input int pl    = ENG_PL_DEF);
    return ((u * w_num + w) * pl) + b;
  endfunction

endpackage

// File: rtl/eng_outbuf_if.sv
// Engine->outbuf write handshake plus the outbuf->consumer beat stream.
interface eng_outbuf_if #(
  parameter int ENTRY_W = 1024,
  parameter int OUT_W   = 64
);
  logic [ENTRY_W-1:0] eng_outbuf_dout;
  logic               eng_outbuf_wr_req;
  logic               outbuf_eng_wr_ack;
  logic               outbuf_eng_full;
  logic [OUT_W-1:0]   outbuf_rd_data;
  logic               outbuf_rd_valid;
  logic               outbuf_rd_ready;
  logic               outbuf_rd_last;

  modport master (
    output eng_outbuf_dout, eng_outbuf_wr_req, outbuf_rd_ready,
    input  outbuf_eng_wr_ack, outbuf_eng_full, outbuf_rd_data, outbuf_rd_valid, outbuf_rd_last
  );

  modport slave (
    input  eng_outbuf_dout, eng_outbuf_wr_req, outbuf_rd_ready,
    output outbuf_eng_wr_ack, outbuf_eng_full, outbuf_rd_data, outbuf_rd_valid, outbuf_rd_last
  );
endinterface

// File: rtl/eng_outbuf_mem.sv
// DEPTH x ENTRY_W entry storage: one synchronous write port, asynchronous read of
// the selected entry. Contents are intentionally not reset.
module outbuf_mem #(
  parameter int DEPTH   = 4,
  parameter int ENTRY_W = 1024,
  parameter int AW      = 2
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic [AW-1:0]      rd_addr,
  output logic [ENTRY_W-1:0] rd_data
);
  logic [ENTRY_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/eng_outbuf.sv
// Entry FIFO draining each stored parity entry as OUT_W-bit beats.
// Optional OUTBUF_ENTRY_CNT_EN adds a saturating drained-entry counter.
//   state   | meaning
//   EMPTY   | count == 0, no beat offered
//   SERVING | beat_cnt selects beat 0..BEATS-1 of the head entry
module eng_outbuf
  import eng_pkg::*;
#(
  parameter int PCK_TREE_XOR_UNITS_NUM = ENG_UNITS_DEF,
  parameter int W                      = ENG_W_DEF,
  parameter int PACKET_LENGTH          = ENG_PL_DEF,
  parameter int DEPTH                  = 4,
  parameter int OUT_W                  = 64
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       outbuf_flush,
  eng_outbuf_if.slave                bus,
  output logic                       outbuf_empty,
  output logic [$clog2(DEPTH+1)-1:0] outbuf_count
`ifdef OUTBUF_ENTRY_CNT_EN
  ,
  output logic [31:0]                outbuf_entry_cnt
`endif
);
  localparam int ENTRY_W = entry_width(PCK_TREE_XOR_UNITS_NUM, W, PACKET_LENGTH);
  localparam int BEATS   = ENTRY_W / OUT_W;
  localparam int PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CW      = $clog2(DEPTH + 1);

  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [BW-1:0]      beat_cnt;
  logic [CW-1:0]      count;
  logic [ENTRY_W-1:0] head_entry;
  logic               full, rd_valid, last_beat, push, beat_xfer, pop;

  assign full      = (count == CW'(DEPTH));
  assign rd_valid  = (count != '0);
  assign last_beat = (beat_cnt == BW'(BEATS - 1));
  // full is registered, so a pop in the same cycle never frees a slot for this push
  assign push      = bus.eng_outbuf_wr_req & ~full & ~outbuf_flush;
  assign beat_xfer = rd_valid & bus.outbuf_rd_ready;
  assign pop       = beat_xfer & last_beat;

  outbuf_mem #(.DEPTH(DEPTH), .ENTRY_W(ENTRY_W), .AW(PW)) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (bus.eng_outbuf_dout),
    .rd_addr (rd_ptr),
    .rd_data (head_entry)
  );

  always_comb begin
    bus.outbuf_rd_data = '0;
    if (rd_valid) bus.outbuf_rd_data = head_entry[int'(beat_cnt) * OUT_W +: OUT_W];
  end

  assign bus.outbuf_rd_valid   = rd_valid;
  assign bus.outbuf_rd_last    = rd_valid & last_beat;
  assign bus.outbuf_eng_wr_ack = push;
  assign bus.outbuf_eng_full   = full;
  assign outbuf_empty          = (count == '0);
  assign outbuf_count          = count;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      beat_cnt <= '0;
      count    <= '0;
    end else if (outbuf_flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      beat_cnt <= '0;
      count    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (beat_xfer) begin
        if (last_beat) begin
          beat_cnt <= '0;
          rd_ptr   <= rd_ptr + 1'b1;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef OUTBUF_ENTRY_CNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                outbuf_entry_cnt <= '0;
    else if (outbuf_flush)                    outbuf_entry_cnt <= '0;
    else if (pop && (outbuf_entry_cnt != '1)) outbuf_entry_cnt <= outbuf_entry_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_eng_outbuf.sv
// Bench for eng_outbuf: hand-derived vector table, directed backpressure/reset
// sequences and random traffic, all checked against a queue-based reference.
module tb_eng_outbuf;
  localparam int UNITS = 2, WN = 4, PL = 2, OUT_W = 8, DEPTH = 2;
  localparam int ENTRY_W = UNITS * WN * PL;
  localparam int BEATS   = ENTRY_W / OUT_W;

  logic       clk = 1'b0;
  logic       rstn;
  logic       flush;
  logic       empty;
  logic [1:0] count;
`ifdef OUTBUF_ENTRY_CNT_EN
  logic [31:0] entry_cnt;
`endif

  eng_outbuf_if #(.ENTRY_W(ENTRY_W), .OUT_W(OUT_W)) ifc ();

  eng_outbuf #(
    .PCK_TREE_XOR_UNITS_NUM(UNITS), .W(WN), .PACKET_LENGTH(PL),
    .DEPTH(DEPTH), .OUT_W(OUT_W)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .outbuf_flush (flush),
    .bus          (ifc),
    .outbuf_empty (empty),
    .outbuf_count (count)
`ifdef OUTBUF_ENTRY_CNT_EN
    ,
    .outbuf_entry_cnt (entry_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] mq[$];
  int          mbeat;
  logic [31:0] mecnt;
  logic [7:0]  got[$];

  typedef struct {
    logic        req, ready, fl;
    logic [15:0] dout;
    logic        ack, valid, last;
    logic [7:0]  data;
    int          cnt;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic req, input logic ready, input logic fl, input logic [15:0] dout);
    ifc.eng_outbuf_wr_req = req;
    ifc.outbuf_rd_ready   = ready;
    ifc.eng_outbuf_dout   = dout;
    flush                 = fl;
  endtask

  task automatic model_check();
    logic        vld, full;
    logic [15:0] head;
    logic [7:0]  edata;
    vld   = (mq.size() != 0);
    full  = (mq.size() == DEPTH);
    edata = 8'h00;
    if (vld) begin
      head  = mq[0];
      edata = head[mbeat*OUT_W +: OUT_W];
    end
    chk("m_ack",   32'(ifc.outbuf_eng_wr_ack), 32'(ifc.eng_outbuf_wr_req & ~full & ~flush));
    chk("m_full",  32'(ifc.outbuf_eng_full),   32'(full));
    chk("m_empty", 32'(empty),                 32'(!vld));
    chk("m_count", 32'(count),                 32'(mq.size()));
    chk("m_valid", 32'(ifc.outbuf_rd_valid),   32'(vld));
    chk("m_data",  32'(ifc.outbuf_rd_data),    32'(edata));
    chk("m_last",  32'(ifc.outbuf_rd_last),    32'(vld && mbeat == BEATS - 1));
`ifdef OUTBUF_ENTRY_CNT_EN
    chk("m_entry_cnt", entry_cnt, mecnt);
`endif
  endtask

  task automatic advance();
    logic vld, full;
    if (ifc.outbuf_rd_valid && ifc.outbuf_rd_ready) got.push_back(ifc.outbuf_rd_data);
    vld  = (mq.size() != 0);
    full = (mq.size() == DEPTH);
    if (flush) begin
      mq.delete();
      mbeat = 0;
      mecnt = 0;
    end else begin
      if (vld && ifc.outbuf_rd_ready) begin
        if (mbeat == BEATS - 1) begin
          void'(mq.pop_front());
          mbeat = 0;
          if (mecnt != 32'hFFFF_FFFF) mecnt++;
        end else begin
          mbeat++;
        end
      end
      if (ifc.eng_outbuf_wr_req && !full) mq.push_back(ifc.eng_outbuf_dout);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input logic req, input logic ready, input logic fl, input logic [15:0] dout);
    drive(req, ready, fl, dout);
    #2;
    model_check();
    advance();
  endtask

  vec_t vt[18];

  initial begin
    rstn = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    mbeat = 0;
    mecnt = 0;
    #12;
    chk("rst_valid", 32'(ifc.outbuf_rd_valid), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full",  32'(ifc.outbuf_eng_full), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_data",  32'(ifc.outbuf_rd_data), 0);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // req ready flush dout | ack valid last data count
    vt[0]  = '{1,1,0,16'hA55A, 1,0,0,8'h00,0};
    vt[1]  = '{0,1,0,16'h0000, 0,1,0,8'h5A,1};
    vt[2]  = '{0,1,0,16'h0000, 0,1,1,8'hA5,1};
    vt[3]  = '{1,0,0,16'h1111, 1,0,0,8'h00,0};
    vt[4]  = '{1,0,0,16'h2222, 1,1,0,8'h11,1};
    vt[5]  = '{1,0,0,16'h3333, 0,1,0,8'h11,2};
    vt[6]  = '{1,1,0,16'h3333, 0,1,0,8'h11,2};
    vt[7]  = '{1,0,0,16'h3333, 0,1,1,8'h11,2};
    vt[8]  = '{1,1,0,16'h4444, 0,1,1,8'h11,2};
    vt[9]  = '{1,0,0,16'h4444, 1,1,0,8'h22,1};
    vt[10] = '{0,1,0,16'h0000, 0,1,0,8'h22,2};
    vt[11] = '{0,1,0,16'h0000, 0,1,1,8'h22,2};
    vt[12] = '{0,1,0,16'h0000, 0,1,0,8'h44,1};
    vt[13] = '{1,0,1,16'h5555, 0,1,1,8'h44,1};
    vt[14] = '{1,1,0,16'hBEEF, 1,0,0,8'h00,0};
    vt[15] = '{0,1,0,16'h0000, 0,1,0,8'hEF,1};
    vt[16] = '{0,1,0,16'h0000, 0,1,1,8'hBE,1};
    vt[17] = '{0,1,0,16'h0000, 0,0,0,8'h00,0};

    for (int i = 0; i < 18; i++) begin
      drive(vt[i].req, vt[i].ready, vt[i].fl, vt[i].dout);
      #2;
      chk($sformatf("v%0d_ack", i),   32'(ifc.outbuf_eng_wr_ack), 32'(vt[i].ack));
      chk($sformatf("v%0d_valid", i), 32'(ifc.outbuf_rd_valid),   32'(vt[i].valid));
      chk($sformatf("v%0d_last", i),  32'(ifc.outbuf_rd_last),    32'(vt[i].last));
      chk($sformatf("v%0d_data", i),  32'(ifc.outbuf_rd_data),    32'(vt[i].data));
      chk($sformatf("v%0d_count", i), 32'(count),                 32'(vt[i].cnt));
      chk($sformatf("v%0d_full", i),  32'(ifc.outbuf_eng_full),   32'(vt[i].cnt == DEPTH));
      model_check();
      advance();
    end

    // Backpressure: ready toggles every cycle, beats must come out 11,11,22,22
    got.delete();
    cycle(1, 0, 0, 16'h1111);
    cycle(1, 0, 0, 16'h2222);
    for (int i = 0; i < 10; i++) cycle(0, logic'(i % 2), 0, 16'h0000);
    chk("bp_n_beats", 32'(got.size()), 4);
    if (got.size() == 4) begin
      chk("bp_b0", 32'(got[0]), 32'h11);
      chk("bp_b1", 32'(got[1]), 32'h11);
      chk("bp_b2", 32'(got[2]), 32'h22);
      chk("bp_b3", 32'(got[3]), 32'h22);
    end

    // Async reset between beats of an entry
    cycle(1, 0, 0, 16'h1234);
    cycle(0, 1, 0, 16'h0000);
    rstn = 1'b0;
    drive(0, 1, 0, 16'h0000);
    #1;
    chk("arst_valid", 32'(ifc.outbuf_rd_valid), 0);
    chk("arst_last",  32'(ifc.outbuf_rd_last), 0);
    chk("arst_data",  32'(ifc.outbuf_rd_data), 0);
    chk("arst_count", 32'(count), 0);
    chk("arst_empty", 32'(empty), 1);
    chk("arst_ack",   32'(ifc.outbuf_eng_wr_ack), 0);
`ifdef OUTBUF_ENTRY_CNT_EN
    chk("arst_entry_cnt", entry_cnt, 0);
`endif
    mq.delete();
    mbeat = 0;
    mecnt = 0;
    #3 rstn = 1'b1;
    @(posedge clk);
    #1;
    got.delete();
    cycle(1, 1, 0, 16'h5678);
    cycle(0, 1, 0, 16'h0000);
    cycle(0, 1, 0, 16'h0000);
    chk("post_rst_n", 32'(got.size()), 2);
    if (got.size() == 2) begin
      chk("post_rst_b0", 32'(got[0]), 32'h78);
      chk("post_rst_b1", 32'(got[1]), 32'h56);
    end
`ifdef OUTBUF_ENTRY_CNT_EN
    chk("post_rst_entry_cnt", entry_cnt, 1);
`endif

    // Random traffic against the queue model
    for (int i = 0; i < 800; i++) begin
      cycle(logic'($urandom_range(3, 0) != 0),
            logic'($urandom_range(2, 0) != 0),
            logic'($urandom_range(39, 0) == 0),
            16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/eng_outbuf.md
Name: eng_outbuf

Overview:
- Output buffer at the far end of the engine→outbuf write interface.
- Accepts complete parity entries from the engine pipeline via wr_req/full/wr_ack and stores them in a DEPTH-entry FIFO.
- Drains each entry to the downstream consumer as OUT_W-bit beats over a valid/ready stream.
- Reports full/empty/occupancy to the engine and to control.

Parameters:
- PCK_TREE_XOR_UNITS_NUM, 128, parity packet units per entry.
- W, 4, word width (bit-planes per unit).
- PACKET_LENGTH, 2, bits per packet.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- OUT_W, 64, read beat width; ENTRY_W = PCK_TREE_XOR_UNITS_NUM*W*PACKET_LENGTH must be a multiple of OUT_W.
- BEATS, ENTRY_W/OUT_W, derived; beats per entry.

Ports:
- clk  in  1  clock.
- rstn  in  1  async active-low reset.
- outbuf_flush  in  1  sync flush (driven from eng_rstn inverted by control).
- eng_outbuf_dout  in  ENTRY_W  flattened entry; bit ((u*W+w)*PACKET_LENGTH)+b = unit u, plane w, packet bit b.
- eng_outbuf_wr_req  in  1  write request.
- outbuf_eng_wr_ack  out  1  write accepted this cycle.
- outbuf_eng_full  out  1  FIFO full.
- outbuf_rd_data  out  OUT_W  current beat.
- outbuf_rd_valid  out  1  beat valid.
- outbuf_rd_ready  in  1  consumer ready.
- outbuf_rd_last  out  1  final beat of entry.
- outbuf_empty  out  1  no stored entries.
- outbuf_count  out  $clog2(DEPTH+1)  occupancy in entries.

Behaviour:
- Reset (rstn low, async): wr_ptr=rd_ptr=0, beat_cnt=0, count=0.
  - Outputs: full=0, empty=1, rd_valid=0, rd_last=0, rd_data=0, wr_ack=0.
  - Storage array is not reset.
- Write:
  - push = wr_req & ~full & ~flush.
  - wr_ack = push, combinational, same cycle.
  - On push: mem[wr_ptr] <= dout; wr_ptr wraps modulo DEPTH.
  - wr_req while full or flush: ignored, no ack, no state change.
- Read:
  - rd_valid = (count != 0).
  - rd_data = mem[rd_ptr][beat_cnt*OUT_W +: OUT_W] when valid, else 0.
  - rd_last = rd_valid & (beat_cnt == BEATS-1).
  - Beat transfers on rd_valid & rd_ready. Non-last beat: beat_cnt++. Last beat: beat_cnt=0, rd_ptr++ (wrap), entry popped.
  - rd_data/rd_last stay stable while valid & ~ready.
- Latency: entry written at edge N is visible as rd_valid from cycle N+1; there is no same-cycle bypass when empty.
- Count: +1 on push, -1 on pop, unchanged on simultaneous push and pop.
- full = (count == DEPTH); empty = (count == 0). Both derive from the registered count.
  - When full, a push is refused even if a pop completes the same cycle; full drops the cycle after the pop.
- Flush (sync, priority over push/pop):
  - Pointers, beat_cnt and count go to 0 at the next edge.
  - An in-progress entry is discarded mid-beat; rd_valid=0 the following cycle.
- Reset mid-operation: async clear as above; the partial entry is lost.
- Beat counter state: EMPTY (count=0) / SERVING (beat 0..BEATS-1). No further FSM.

Optional Feature:
- Macro OUTBUF_ENTRY_CNT_EN.
- Defined:
  - Adds output outbuf_entry_cnt [31:0], a saturating count (stops at 0xFFFFFFFF) of entries fully drained (last-beat transfers).
  - Cleared by rstn and by flush.
- Undefined: port and counter are absent. All other behaviour is identical.

Decomposition:
- Package eng_pkg:
  - ENTRY_W computation function.
  - Flattening index function unit_plane_bit_idx(u,w,b).
  - Typedef entry_t (logic [ENTRY_W-1:0]).
  - Shared engine defaults (W, PACKET_LENGTH, PCK_TREE_XOR_UNITS_NUM).
- Sub-module outbuf_mem: DEPTH x ENTRY_W register array with write port and async read of the selected entry. Beat slicing and control stay in eng_outbuf.

Test Plan (PCK_TREE_XOR_UNITS_NUM=2, W=4, PACKET_LENGTH=2 → ENTRY_W=16; OUT_W=8 → BEATS=2; DEPTH=2):
- Single entry: wr_req with dout=16'hA55A, rd_ready=1.
  - Same cycle: wr_ack=1.
  - Next cycle: rd_data=8'h5A, rd_last=0; then rd_data=8'hA5, rd_last=1.
  - Then empty=1, count=0.
- Fill to full: push 16'h1111 and 16'h2222 with rd_ready=0 → count=2, full=1. Third wr_req gets no ack; data 16'h3333 is never output.
- Backpressure: rd_ready toggles 0/1 each cycle → each beat held stable while ready=0; order 11,11,22,22; no duplication or loss.
- Full with simultaneous pop: at full, hold wr_req=1 while the last beat of 16'h1111 drains → no ack that cycle. Ack next cycle (full=0); count returns to 2.
- Flush: with one entry in SERVING after beat 0, assert flush for 1 cycle with wr_req=1 → no ack. Next cycle: count=0, rd_valid=0, empty=1. A subsequent write of 16'hBEEF outputs EF then BE.
- Async reset mid-drain: drop rstn between beats → all outputs at reset values immediately; after release the first write drains correctly from beat 0. With OUTBUF_ENTRY_CNT_EN defined, check entry_cnt is 0 after reset and increments once per completed entry.
